// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I pipeline types and constants for the fetch slice
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        TRAP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [31:0]     instr;
        logic            valid;
    } ifid_t;

    // A bubble carries no PC so downstream never mistakes it for a real link value.
    localparam ifid_t IFID_BUBBLE = '{pc: '0, pc_plus4: '0, instr: NOP_INSTR, valid: 1'b0};

endpackage

// File: rtl/if_id_register.sv
// rtl/if_id_register.sv - IF/ID pipeline register; flush beats load, otherwise holds
module if_id_register
    import riscv_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  i_load,
    input  logic  i_flush,
    input  ifid_t i_data,
    output ifid_t o_data
);

    ifid_t r_ifid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ifid <= IFID_BUBBLE;
        end else if (i_flush) begin
            r_ifid <= IFID_BUBBLE;
        end else if (i_load) begin
            r_ifid <= i_data;
        end
    end

    assign o_data = r_ifid;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I IF stage: PC, boot/run/trap FSM, IF/ID capture
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR = 32'h0000_00F0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_target,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_instr,
    output logic [XLEN-1:0] ifid_pc,
    output logic [XLEN-1:0] ifid_pc_plus4,
    output logic [31:0]     ifid_instr,
    output logic            ifid_valid,
    output logic            trap
);

    fetch_state_t    r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_trap;

    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_target;
    logic            w_misaligned;
    logic            w_run;
    logic            w_load;
    logic            w_flush;
    ifid_t           w_ifid_d;
    ifid_t           w_ifid_q;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign w_misaligned = (redirect_target[1:0] != 2'b00);
    assign w_target     = redirect_target;
`else
    assign w_misaligned = 1'b0;
    assign w_target     = redirect_target & {{(XLEN-2){1'b1}}, 2'b00};
`endif

    assign w_pc_plus4 = r_pc + XLEN'(4);
    assign w_run      = (r_state == RUN);
    assign w_flush    = w_run && redirect;
    assign w_load     = w_run && !redirect && !stall;
    assign w_ifid_d   = '{pc: r_pc, pc_plus4: w_pc_plus4, instr: imem_instr, valid: 1'b1};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= BOOT;
            r_pc    <= RESET_PC;
            r_trap  <= 1'b0;
        end else begin
            case (r_state)
                BOOT: r_state <= RUN;
                RUN: begin
                    if (redirect) begin
                        if (w_misaligned) begin
                            r_pc    <= TRAP_VECTOR;
                            r_trap  <= 1'b1;
                            r_state <= TRAP;
                        end else begin
                            r_pc <= w_target;
                        end
                    end else if (!stall) begin
                        r_pc <= w_pc_plus4;
                    end
                end
                TRAP:    r_pc <= TRAP_VECTOR;
                default: r_state <= BOOT;
            endcase
        end
    end

    if_id_register u_if_id (
        .clk     (clk),
        .rst     (reset),
        .i_load  (w_load),
        .i_flush (w_flush),
        .i_data  (w_ifid_d),
        .o_data  (w_ifid_q)
    );

    assign imem_addr     = r_pc;
    assign ifid_pc       = w_ifid_q.pc;
    assign ifid_pc_plus4 = w_ifid_q.pc_plus4;
    assign ifid_instr    = w_ifid_q.instr;
    assign ifid_valid    = w_ifid_q.valid;
    assign trap          = r_trap;

endmodule
